// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Bytes touched by an access; 0 for the illegal size encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Write byte-enable for a size; 0 for the illegal encoding.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extractor: picks byte/half/word from the low lanes and extends.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_rdata,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_result
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = ~i_unsigned & i_rdata[7];
  assign w_sign_h = ~i_unsigned & i_rdata[15];

  // Memory already aligns byte 0 to addr, so extraction is always from bit 0.
  always_comb begin
    o_result = i_rdata;
    case (i_size)
      SZ_B:    o_result = {{(XLEN-8){w_sign_b}}, i_rdata[7:0]};
      SZ_H:    o_result = {{(XLEN-16){w_sign_h}}, i_rdata[15:0]};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request handshake, bounds check, data_mem drive, registered response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wen,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  localparam logic [AWIDTH:0] MEMSIZE = (AWIDTH+1)'(1) << AWIDTH;

  lsu_state_e        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [AWIDTH-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_fault;
  logic              r_wen;
  logic [3:0]        r_wmask;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic [2:0]        w_nbytes;
  logic [AWIDTH:0]   w_end;
  logic              w_fault;
  logic              w_store_ok;
  logic [XLEN-1:0]   w_ext;

  // Fault check on the incoming request; end address is one bit wider so it never wraps.
  assign w_nbytes   = size_bytes(req_size);
  assign w_end      = {1'b0, req_addr[AWIDTH-1:0]} + (AWIDTH+1)'(w_nbytes);
  assign w_fault    = (req_size == 2'd3) || (|req_addr[XLEN-1:AWIDTH]) || (w_end > MEMSIZE);
  assign w_store_ok = req_we & ~w_fault;

  lsu_load_ext #(.XLEN(XLEN)) u_ext (
    .i_rdata    (mem_rdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_ext)
  );

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_wen    = r_wen;
  assign mem_wmask  = r_wmask;

  // FSM: capture in IDLE (write strobe armed for the ACCESS cycle), sample memory in ACCESS, hold in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fault    <= 1'b0;
      r_wen      <= 1'b0;
      r_wmask    <= 4'b0000;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr[AWIDTH-1:0];
            r_wdata    <= req_wdata;
            r_fault    <= w_fault;
            r_wen      <= w_store_ok;
            r_wmask    <= w_store_ok ? size_mask(req_size) : 4'b0000;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          r_wen   <= 1'b0;
          r_wmask <= 4'b0000;
          r_rdata <= (r_we || r_fault) ? '0 : w_ext;
          r_err   <= r_fault;
          r_state <= RESP;
        end
        RESP: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
